// File: rtl/vector_operand_packer_if.sv
// Operand packer bus: lane-serial load stream in, packed operand pair out.
//   start/funct_in   : begin a load and supply the operation code
//   in_valid/in_data : one lane byte per beat, lane 0 first
//   in_ready         : packer is accepting beats
//   busy             : packer is not idle
//   op1/op2/funct    : assembled operands and captured operation code
//   flag/ack         : operands valid for the ALU / ALU has taken them
interface vector_operand_packer_if #(
  parameter int unsigned LANES  = 24,
  parameter int unsigned LANE_W = 8
);
  logic                    start;
  logic [2:0]              funct_in;
  logic                    in_valid;
  logic [LANE_W-1:0]       in_data;
  logic                    in_ready;
  logic                    busy;
  logic [LANES*LANE_W-1:0] op1;
  logic [LANES*LANE_W-1:0] op2;
  logic [2:0]              funct;
  logic                    flag;
  logic                    ack;

  modport master (
    output start, funct_in, in_valid, in_data, ack,
    input  in_ready, busy, op1, op2, funct, flag
  );

  modport slave (
    input  start, funct_in, in_valid, in_data, ack,
    output in_ready, busy, op1, op2, funct, flag
  );
endinterface

// File: rtl/vector_operand_packer.sv
// Collects two LANES-wide operands from a lane-serial byte stream and
// presents them, with a captured operation code, to a vector ALU.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset
//   bus  : vector_operand_packer_if slave (load stream in, operands out)
module vector_operand_packer #(
  parameter int unsigned LANES  = 24,
  parameter int unsigned LANE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  vector_operand_packer_if.slave   bus
);

  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned VEC_W = LANES * LANE_W;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] lane;
  logic [VEC_W-1:0] op1_q;
  logic [VEC_W-1:0] op2_q;
  logic [2:0]       funct_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             flag_q;

  // Control FSM and operand storage; status outputs are registered
  // alongside the state so they always match its decode.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      lane       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      funct_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            funct_q    <= bus.funct_in;
            lane       <= '0;
            state      <= LOAD_A;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        LOAD_A: begin
          if (bus.in_valid) begin
            for (int i = 0; i < int'(LANES); i++) begin
              if (lane == CNT_W'(i)) op1_q[i*LANE_W +: LANE_W] <= bus.in_data;
            end
            if (lane == LAST_LANE) begin
              lane  <= '0;
              state <= LOAD_B;
            end else begin
              lane <= lane + CNT_W'(1);
            end
          end
        end

        LOAD_B: begin
          if (bus.in_valid) begin
            for (int i = 0; i < int'(LANES); i++) begin
              if (lane == CNT_W'(i)) op2_q[i*LANE_W +: LANE_W] <= bus.in_data;
            end
            if (lane == LAST_LANE) begin
              lane       <= '0;
              state      <= ISSUE;
              in_ready_q <= 1'b0;
              flag_q     <= 1'b1;
            end else begin
              lane <= lane + CNT_W'(1);
            end
          end
        end

        ISSUE: begin
          // Start in the ack cycle is dropped: it was sampled outside IDLE.
          if (bus.ack) begin
            state  <= IDLE;
            flag_q <= 1'b0;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          flag_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op1      = op1_q;
  assign bus.op2      = op2_q;
  assign bus.funct    = funct_q;
  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.flag     = flag_q;

endmodule

// File: tb/tb_vector_operand_packer.sv
// Randomized self-checking bench for vector_operand_packer.
module tb_vector_operand_packer;

  localparam int unsigned LANES  = 24;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned VW     = LANES * LANE_W;
  localparam int unsigned NB     = 2 * LANES;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vector_operand_packer_if #(.LANES(LANES), .LANE_W(LANE_W)) bus ();

  vector_operand_packer #(.LANES(LANES), .LANE_W(LANE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]    data [NB];
  logic [2:0]    cur_f;
  logic [VW-1:0] exp1;
  logic [VW-1:0] exp2;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: operand A is the first LANES bytes of the stream, B the rest,
  // lane i of each at bits [8i+7:8i].
  task automatic build_expect();
    for (int i = 0; i < int'(LANES); i++) begin
      exp1[i*8 +: 8] = data[i];
      exp2[i*8 +: 8] = data[int'(LANES) + i];
    end
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
  // noise drives random start/funct_in/ack, all of which must be ignored.
  task automatic do_load(input logic [2:0] f, input int mode, input bit noise);
    int k;
    int cyc;
    bit v;
    bit early;
    bus.start    = 1'b1;
    bus.funct_in = f;
    step();
    bus.start = 1'b0;
    cur_f = f;
    check("load_busy", VW'(bus.busy), VW'(1));
    check("load_ready", VW'(bus.in_ready), VW'(1));
    k = 0;
    cyc = 0;
    early = 1'b0;
    while (k < int'(NB) && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? data[k] : 8'($urandom);
      if (noise) begin
        bus.start    = 1'($urandom_range(0, 1));
        bus.funct_in = 3'($urandom);
        bus.ack      = 1'($urandom_range(0, 1));
      end
      step();
      cyc++;
      if (v) k++;
      if (k < int'(NB) && bus.flag) early = 1'b1;
      if (k < int'(NB) && !bus.in_ready) early = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    bus.ack      = 1'b0;
    check("load_timeout", VW'(k), VW'(NB));
    check("flag_early", VW'(early), VW'(0));
    if (mode == 0) check("latency", VW'(cyc), VW'(NB));
    build_expect();
    check("op1", bus.op1, exp1);
    check("op2", bus.op2, exp2);
    check("funct", VW'(bus.funct), VW'(cur_f));
    check("issue_flag", VW'(bus.flag), VW'(1));
    check("issue_ready", VW'(bus.in_ready), VW'(0));
    check("issue_busy", VW'(bus.busy), VW'(1));
  endtask

  // Hold ISSUE for n cycles under junk stream/start, then ack.
  task automatic ack_hold(input int n, input bit coincident);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.start    = 1'($urandom_range(0, 1));
      bus.funct_in = 3'($urandom);
      step();
      check("hold_ready", VW'(bus.in_ready), VW'(0));
      check("hold_flag", VW'(bus.flag), VW'(1));
      check("hold_op1", bus.op1, exp1);
      check("hold_op2", bus.op2, exp2);
    end
    bus.in_valid = 1'b0;
    bus.start    = coincident;
    bus.funct_in = ~cur_f;
    bus.ack      = 1'b1;
    step();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    check("ack_flag", VW'(bus.flag), VW'(0));
    check("ack_busy", VW'(bus.busy), VW'(0));
    check("idle_op1", bus.op1, exp1);
    check("idle_op2", bus.op2, exp2);
    check("idle_funct", VW'(bus.funct), VW'(cur_f));
    if (coincident) begin
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      check("coinc_busy", VW'(bus.busy), VW'(0));
      check("coinc_ready", VW'(bus.in_ready), VW'(0));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_op1"}, bus.op1, '0);
    check({tag, "_op2"}, bus.op2, '0);
    check({tag, "_funct"}, VW'(bus.funct), '0);
    check({tag, "_flag"}, VW'(bus.flag), '0);
    check({tag, "_ready"}, VW'(bus.in_ready), '0);
    check({tag, "_busy"}, VW'(bus.busy), '0);
  endtask

  initial begin
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.funct_in = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.ack      = 1'b0;
    cur_f        = '0;
    exp1         = '0;
    exp2         = '0;
    step();
    step();
    check_zero("reset");
    rst = 1'b1;
    step();

    // Basic load 0x00..0x2F, then ack hold with coincident start/ack.
    for (int i = 0; i < int'(NB); i++) data[i] = 8'(i);
    do_load(3'b001, 0, 1'b0);
    ack_hold(10, 1'b1);

    // Same stream with a bubble every other cycle.
    do_load(3'b001, 1, 1'b0);
    ack_hold(2, 1'b0);

    // Random data, random gaps, ignored control noise.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < int'(NB); i++) data[i] = 8'($urandom);
      do_load(3'($urandom), 2, 1'b1);
      ack_hold(int'($urandom_range(0, 5)), 1'(r % 2));
    end

    // Reset after 30 beats discards the partial load.
    bus.start    = 1'b1;
    bus.funct_in = 3'b101;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      step();
    end
    rst       = 1'b0;
    bus.start = 1'b1;
    step();
    check_zero("midrst");
    step();
    check_zero("midrst2");
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("post_rst_busy", VW'(bus.busy), VW'(0));

    for (int i = 0; i < int'(NB); i++) data[i] = 8'hA5;
    do_load(3'b110, 0, 1'b0);
    ack_hold(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
